// File: rtl/dmem_arb_pkg.sv
// Shared encodings and defaults for the data-memory arbiter and its grant picker.
// Owner/state codes double as the response-routing tag one cycle after a grant.
package dmem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_A = 2'd1;
  localparam logic [1:0] ST_OWN_B = 2'd2;

  localparam int DEPTH_WORDS_DEF = 64;

  localparam int MAX_BURST_DEF = 4;
  localparam int MAX_BURST_MIN = 1;
  localparam int MAX_BURST_MAX = 15;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-requester grant picker: A has priority, B is forced in after MAX_BURST A grants while waiting.
// Grants are combinational and gated by reset; with DMEM_ARB_STATS_EN it also flags forced B grants.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
`ifdef DMEM_ARB_STATS_EN
  output logic b_forced,
`endif
  output logic b_gnt
);

  // Out-of-range settings are clamped so the 4-bit counter can always reach the limit.
  localparam int LIM = (MAX_BURST > MAX_BURST_MAX) ? MAX_BURST_MAX :
                       (MAX_BURST < MAX_BURST_MIN) ? MAX_BURST_MIN : MAX_BURST;
  localparam logic [3:0] LIM_V = 4'(LIM);

  logic [3:0] burst_cnt;
  logic       limit_hit;
  logic       force_b;

  assign limit_hit = (burst_cnt == LIM_V);

  always_comb begin
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    force_b = 1'b0;
    if (reset) begin
      if (a_req && b_req) begin
        if (limit_hit) begin
          b_gnt   = 1'b1;
          force_b = 1'b1;
        end else begin
          a_gnt = 1'b1;
        end
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  assign b_forced = force_b;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_cnt <= 4'd0;
    end else if (b_gnt || !b_req) begin
      burst_cnt <= 4'd0;
    end else if (a_gnt && !limit_hit && !force_b) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: comb grant, reads return registered 1 cycle later.
// Ungranted requesters simply hold their request; optional DMEM_ARB_STATS_EN adds contention counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int MAX_BURST   = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_WriteData,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  input  logic [DATA_W-1:0] mem_ReadData,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       b_force_cnt,
`endif
  output logic              busy
);

  logic              gnt_any;
  logic              sel_we;
  logic              in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        state;
  logic              resp_rd_q;
  logic              resp_err_q;
`ifdef DMEM_ARB_STATS_EN
  logic              b_forced;
`endif

  dmem_arb_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .clk      (clk),
    .reset    (reset),
    .a_req    (a_req),
    .b_req    (b_req),
    .a_gnt    (a_gnt),
`ifdef DMEM_ARB_STATS_EN
    .b_forced (b_forced),
`endif
    .b_gnt    (b_gnt)
  );

  assign busy    = a_req | b_req;
  assign gnt_any = a_gnt | b_gnt;

  always_comb begin
    sel_we    = b_we;
    sel_addr  = b_addr;
    sel_wdata = b_wdata;
    if (a_gnt) begin
      sel_we    = a_we;
      sel_addr  = a_addr;
      sel_wdata = a_wdata;
    end
  end

  assign in_range      = (sel_addr < ADDR_W'(DEPTH_WORDS));
  assign mem_address   = gnt_any ? sel_addr  : '0;
  assign mem_WriteData = gnt_any ? sel_wdata : '0;
  assign mem_MemWrite  = gnt_any &  sel_we & in_range;
  assign mem_MemRead   = gnt_any & ~sel_we & in_range;

  // state records last cycle's owner, so it also tags which port the response belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      resp_rd_q  <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state      <= a_gnt ? ST_OWN_A : (b_gnt ? ST_OWN_B : ST_IDLE);
      resp_rd_q  <= gnt_any & ~sel_we;
      resp_err_q <= gnt_any & ~in_range;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (a_gnt && !a_we) a_rdata <= in_range ? mem_ReadData : '0;
      if (b_gnt && !b_we) b_rdata <= in_range ? mem_ReadData : '0;
    end
  end

  assign a_rvalid = (state == ST_OWN_A) & resp_rd_q;
  assign a_err    = (state == ST_OWN_A) & resp_err_q;
  assign b_rvalid = (state == ST_OWN_B) & resp_rd_q;
  assign b_err    = (state == ST_OWN_B) & resp_err_q;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= 16'd0;
      b_force_cnt  <= 16'd0;
    end else begin
      if (a_req && b_req && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
      if (b_forced && b_force_cnt != 16'hFFFF)        b_force_cnt  <= b_force_cnt + 16'd1;
    end
  end
`endif

endmodule
